// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline-hazard types: register index width, register count and the
// stall/bubble control bundle used by ID, forwarding and the ID/EX register.
package hazard_scoreboard_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int PEND_W   = 4;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic bubble_ex;
  } pipe_ctrl_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bundle: decoded operands and writeback events in,
// stall/bubble/issue controls and scoreboard status out.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic                id_valid;
  reg_idx_t            id_rs1;
  reg_idx_t            id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  reg_idx_t            id_rd;
  logic                id_reg_write;
  logic                id_is_long;
  logic                ex_mem_read;
  reg_idx_t            ex_rd;
  logic                flush;
  logic                lu_done;
  reg_idx_t            lu_rd;
  logic                lu_kill;
  logic                stall_if;
  logic                stall_id;
  logic                bubble_ex;
  logic                issue;
  logic [NUM_REGS-1:0] busy_vec;
  logic [PEND_W-1:0]   pend_count;
  logic [CNT_W-1:0]    stall_cnt;
  logic                err_underflow;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_long, ex_mem_read, ex_rd, flush,
           lu_done, lu_rd, lu_kill,
    input  stall_if, stall_id, bubble_ex, issue, busy_vec, pend_count,
           stall_cnt, err_underflow
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_long, ex_mem_read, ex_rd, flush,
           lu_done, lu_rd, lu_kill,
    output stall_if, stall_id, bubble_ex, issue, busy_vec, pend_count,
           stall_cnt, err_underflow
  );

endinterface

// File: rtl/hazard_scoreboard_regfile.sv
// Pending-write bit per architectural register with set/clear/kill update and
// three effective-busy read ports that treat a same-cycle completion as free.
module hazard_scoreboard_regfile
  import hazard_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                kill,
  input  logic                clr_en,
  input  reg_idx_t            clr_rd,
  input  logic                set_en,
  input  reg_idx_t            set_rd,
  input  reg_idx_t            rd_rs1,
  input  reg_idx_t            rd_rs2,
  input  reg_idx_t            rd_rd,
  output logic                eb_rs1,
  output logic                eb_rs2,
  output logic                eb_rd,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eb_vec;
  logic [NUM_REGS-1:0] busy_next;

  // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
  always_comb begin
    clr_mask = clr_en ? reg_onehot(clr_rd) : '0;
    set_mask = set_en ? reg_onehot(set_rd) : '0;
    eb_vec   = busy_vec & ~clr_mask;
    // Set is applied after clear so a re-issue to the same rd stays pending.
    busy_next    = kill ? '0 : (eb_vec | set_mask);
    busy_next[0] = 1'b0;
  end

  assign eb_rs1 = eb_vec[rd_rs1];
  assign eb_rs2 = eb_vec[rd_rs2];
  assign eb_rd  = eb_vec[rd_rd];

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_next;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector: load-use, RAW/WAW against in-flight long ops and
// the long-op structural limit, plus pending-op and stall performance counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = 32
)(
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);

  pipe_ctrl_t        ctrl;
  logic              load_use, raw, waw, struct_hz, hazard;
  logic              eb_rs1, eb_rs2, eb_rd;
  logic              issue, pend_inc, set_en;
  logic [PEND_W-1:0] pend_count;
  logic [CNT_W-1:0]  stall_cnt;
  logic              err_underflow;

  hazard_scoreboard_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .kill     (sb.lu_kill),
    .clr_en   (sb.lu_done),
    .clr_rd   (sb.lu_rd),
    .set_en   (set_en),
    .set_rd   (sb.id_rd),
    .rd_rs1   (sb.id_rs1),
    .rd_rs2   (sb.id_rs2),
    .rd_rd    (sb.id_rd),
    .eb_rs1   (eb_rs1),
    .eb_rs2   (eb_rs2),
    .eb_rd    (eb_rd),
    .busy_vec (sb.busy_vec)
  );

  always_comb begin
    load_use  = sb.ex_mem_read && (sb.ex_rd != '0) &&
                ((sb.id_rs1_used && (sb.ex_rd == sb.id_rs1)) ||
                 (sb.id_rs2_used && (sb.ex_rd == sb.id_rs2)));
    raw       = (sb.id_rs1_used && eb_rs1) || (sb.id_rs2_used && eb_rs2);
    waw       = sb.id_reg_write && eb_rd;
    // A completion this cycle frees a slot for the op waiting in ID.
    struct_hz = sb.id_is_long && (pend_count == PEND_W'(MAX_PEND)) && !sb.lu_done;
    hazard    = sb.id_valid && (load_use || raw || waw || struct_hz) &&
                !sb.flush && !sb.lu_kill;
    ctrl      = '{stall_if: hazard, stall_id: hazard, bubble_ex: hazard};
  end

  assign issue    = sb.id_valid && !hazard && !sb.flush && !sb.lu_kill;
  assign pend_inc = issue && sb.id_is_long;
  assign set_en   = pend_inc && sb.id_reg_write && (sb.id_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_count    <= '0;
      err_underflow <= 1'b0;
    end else if (sb.lu_kill) begin
      pend_count    <= '0;
    end else begin
      case ({pend_inc, sb.lu_done})
        2'b10:   pend_count <= pend_count + 1'b1;
        2'b01: begin
          if (pend_count == '0) err_underflow <= 1'b1;
          else                  pend_count    <= pend_count - 1'b1;
        end
        default: pend_count <= pend_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt <= '0;
    else if (ctrl.stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign sb.stall_if      = ctrl.stall_if;
  assign sb.stall_id      = ctrl.stall_id;
  assign sb.bubble_ex     = ctrl.bubble_ex;
  assign sb.issue         = issue;
  assign sb.pend_count    = pend_count;
  assign sb.stall_cnt     = stall_cnt;
  assign sb.err_underflow = err_underflow;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic, all compared against a rule-level reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int MAXP = 4;
  localparam int CW   = 6;
  localparam int SAT  = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.CNT_W(CW)) bus ();

  hazard_scoreboard #(.MAX_PEND(MAXP), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit busy_m [NUM_REGS];
  int pend_m;
  int scnt_m;
  bit err_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_eb(input int r);
    return busy_m[r] && !(bus.lu_done && int'(bus.lu_rd) == r);
  endfunction

  function automatic bit m_stall();
    bit lu, raw, waw, st;
    lu  = bus.ex_mem_read && bus.ex_rd != 0 &&
          ((bus.id_rs1_used && bus.ex_rd == bus.id_rs1) ||
           (bus.id_rs2_used && bus.ex_rd == bus.id_rs2));
    raw = (bus.id_rs1_used && bus.id_rs1 != 0 && m_eb(int'(bus.id_rs1))) ||
          (bus.id_rs2_used && bus.id_rs2 != 0 && m_eb(int'(bus.id_rs2)));
    waw = bus.id_reg_write && bus.id_rd != 0 && m_eb(int'(bus.id_rd));
    st  = bus.id_is_long && pend_m == MAXP && !bus.lu_done;
    return bus.id_valid && (lu || raw || waw || st) && !bus.flush && !bus.lu_kill;
  endfunction

  function automatic bit m_issue();
    return bus.id_valid && !m_stall() && !bus.flush && !bus.lu_kill;
  endfunction

  task automatic m_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    pend_m = 0;
    scnt_m = 0;
    err_m  = 1'b0;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0;
    bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_is_long = 0;
    bus.ex_mem_read = 0; bus.ex_rd = 0; bus.flush = 0; bus.lu_done = 0;
    bus.lu_rd = 0; bus.lu_kill = 0;
  endtask

  task automatic check_state(input string tag);
    logic [NUM_REGS-1:0] bv;
    for (int i = 0; i < NUM_REGS; i++) bv[i] = busy_m[i];
    check({tag, ".busy_vec"}, 64'(bus.busy_vec), 64'(bv));
    check({tag, ".pend_count"}, 64'(bus.pend_count), 64'(pend_m));
    check({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(scnt_m));
    check({tag, ".err_underflow"}, 64'(bus.err_underflow), 64'(err_m));
  endtask

  // Let inputs settle, compare combinational outputs against the model.
  task automatic settle(input string tag);
    bit s;
    #1;
    s = m_stall();
    check({tag, ".stall_if"}, 64'(bus.stall_if), 64'(s));
    check({tag, ".stall_id"}, 64'(bus.stall_id), 64'(s));
    check({tag, ".bubble_ex"}, 64'(bus.bubble_ex), 64'(s));
    check({tag, ".issue"}, 64'(bus.issue), 64'(m_issue()));
  endtask

  // Advance one clock, apply the spec's update rules to the model, compare state.
  task automatic tick(input string tag);
    bit s, iss, inc;
    int delta;
    s   = m_stall();
    iss = m_issue();
    inc = iss && bus.id_is_long;
    if (bus.lu_kill) begin
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      pend_m = 0;
    end else begin
      if (bus.lu_done) busy_m[int'(bus.lu_rd)] = 1'b0;
      if (inc && bus.id_reg_write && bus.id_rd != 0) busy_m[int'(bus.id_rd)] = 1'b1;
      delta = int'(inc) - int'(bus.lu_done);
      if (pend_m + delta < 0) err_m = 1'b1;
      else                    pend_m = pend_m + delta;
    end
    if (s && scnt_m < SAT) scnt_m++;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic long_op(input int rd);
    idle();
    bus.id_valid = 1; bus.id_is_long = 1; bus.id_reg_write = 1; bus.id_rd = reg_idx_t'(rd);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_reset();
    #12;
    check("reset.busy_vec", 64'(bus.busy_vec), 64'd0);
    check("reset.pend_count", 64'(bus.pend_count), 64'd0);
    check("reset.stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("reset.err", 64'(bus.err_underflow), 64'd0);
    check("reset.stall", 64'(bus.stall_if), 64'd0);
    rst_n = 1'b1;

    // 1: load-use
    idle();
    bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs1_used = 1;
    settle("t1a");
    check("t1.stall", 64'(bus.bubble_ex), 64'd1);
    check("t1.no_issue", 64'(bus.issue), 64'd0);
    tick("t1a");
    bus.ex_mem_read = 0;
    settle("t1b");
    check("t1.issue", 64'(bus.issue), 64'd1);
    tick("t1b");
    check("t1.stall_cnt", 64'(bus.stall_cnt), 64'd1);

    // 2: long op RAW, released by same-cycle completion
    long_op(7);
    settle("t2a"); tick("t2a");
    check("t2.busy7", 64'(bus.busy_vec[7]), 64'd1);
    check("t2.pend1", 64'(bus.pend_count), 64'd1);
    idle();
    bus.id_valid = 1; bus.id_rs2 = 7; bus.id_rs2_used = 1; bus.id_reg_write = 1; bus.id_rd = 8;
    for (int i = 0; i < 2; i++) begin
      settle("t2b");
      check("t2.raw_stall", 64'(bus.stall_if), 64'd1);
      tick("t2b");
    end
    bus.lu_done = 1; bus.lu_rd = 7;
    settle("t2c");
    check("t2.bypass_issue", 64'(bus.issue), 64'd1);
    tick("t2c");
    check("t2.busy7_clr", 64'(bus.busy_vec[7]), 64'd0);

    // 3: structural limit
    for (int r = 1; r <= MAXP; r++) begin
      long_op(r); settle("t3a"); tick("t3a");
    end
    check("t3.pend_full", 64'(bus.pend_count), 64'(MAXP));
    long_op(10);
    settle("t3b");
    check("t3.struct_stall", 64'(bus.stall_if), 64'd1);
    tick("t3b");
    bus.lu_done = 1; bus.lu_rd = 1;
    settle("t3c");
    check("t3.release", 64'(bus.issue), 64'd1);
    tick("t3c");
    check("t3.pend_held", 64'(bus.pend_count), 64'(MAXP));
    foreach (busy_m[r]) if (busy_m[r]) begin
      idle(); bus.lu_done = 1; bus.lu_rd = reg_idx_t'(r); settle("t3d"); tick("t3d");
    end

    // 4: x0 is never tracked
    long_op(0);
    settle("t4a"); tick("t4a");
    check("t4.busy_zero", 64'(bus.busy_vec), 64'd0);
    check("t4.pend1", 64'(bus.pend_count), 64'd1);
    idle();
    bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rs1_used = 1;
    settle("t4b");
    check("t4.no_stall", 64'(bus.stall_if), 64'd0);
    tick("t4b");
    idle(); bus.lu_done = 1; bus.lu_rd = 0; settle("t4c"); tick("t4c");

    // 5: WAW stall, then flush
    long_op(9); settle("t5a"); tick("t5a");
    long_op(9);
    settle("t5b");
    check("t5.waw", 64'(bus.stall_if), 64'd1);
    bus.flush = 1;
    settle("t5c");
    check("t5.flush_stall", 64'(bus.stall_if), 64'd0);
    check("t5.flush_issue", 64'(bus.issue), 64'd0);
    tick("t5c");
    check("t5.busy9", 64'(bus.busy_vec[9]), 64'd1);

    // 6: kill, underflow, async reset
    long_op(11); settle("t6a"); tick("t6a");
    long_op(12); bus.lu_kill = 1;
    settle("t6b");
    check("t6.kill_issue", 64'(bus.issue), 64'd0);
    tick("t6b");
    check("t6.kill_busy", 64'(bus.busy_vec), 64'd0);
    check("t6.kill_pend", 64'(bus.pend_count), 64'd0);
    idle(); bus.lu_done = 1; bus.lu_rd = 3;
    settle("t6c"); tick("t6c");
    check("t6.err", 64'(bus.err_underflow), 64'd1);
    idle(); settle("t6d"); tick("t6d");
    check("t6.err_sticky", 64'(bus.err_underflow), 64'd1);
    long_op(13); settle("t6e"); tick("t6e");
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_state("t6.async_rst");
    #3 rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      idle();
      bus.id_valid     = ($urandom_range(0, 9) != 0);
      bus.id_rs1       = reg_idx_t'($urandom_range(0, 7));
      bus.id_rs2       = reg_idx_t'($urandom_range(0, 7));
      bus.id_rs1_used  = $urandom_range(0, 1) == 1;
      bus.id_rs2_used  = $urandom_range(0, 1) == 1;
      bus.id_rd        = reg_idx_t'($urandom_range(0, 7));
      bus.id_reg_write = $urandom_range(0, 3) != 0;
      bus.id_is_long   = $urandom_range(0, 2) == 0;
      bus.ex_mem_read  = $urandom_range(0, 3) == 0;
      bus.ex_rd        = reg_idx_t'($urandom_range(0, 7));
      bus.flush        = $urandom_range(0, 15) == 0;
      bus.lu_kill      = $urandom_range(0, 59) == 0;
      bus.lu_done      = (pend_m > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      bus.lu_rd        = reg_idx_t'($urandom_range(0, 7));
      settle("rnd");
      tick("rnd");
    end

    // Stall counter saturation
    idle();
    bus.ex_mem_read = 1; bus.ex_rd = 3; bus.id_valid = 1; bus.id_rs2 = 3; bus.id_rs2_used = 1;
    for (int c = 0; c < SAT + 8; c++) begin
      settle("sat"); tick("sat");
    end
    check("sat.stall_cnt", 64'(bus.stall_cnt), 64'(SAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
